// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory-bus arbiter slice.
//   state_t          : arbiter FSM states
//   ADDR_W_DEF/DATA_W_DEF : default bus widths
//   PORT_IF / PORT_D : port identifiers used for grant and last-grant
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  localparam int ADDR_W_DEF = 27;
  localparam int DATA_W_DEF = 32;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

endpackage

// File: rtl/mem_rr_select.sv
// Two-input round-robin selector.
//   clk, reset : clock, synchronous active-low reset
//   if_req     : fetch port pending
//   d_req      : data port pending
//   take       : the current grant is being committed (IDLE exit)
//   grant      : selected port (PORT_IF / PORT_D), valid when a request is pending
module mem_rr_select
  import mem_bus_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic if_req,
  input  logic d_req,
  input  logic take,
  output logic grant
);

  logic last_grant;

  // On contention the port that did not win last time goes first.
  always_comb begin
    grant = PORT_IF;
    if (d_req && !if_req) begin
      grant = PORT_D;
    end else if (d_req && if_req) begin
      grant = (last_grant == PORT_IF) ? PORT_D : PORT_IF;
    end
  end

  // Resetting to the fetch port makes the data port win the first contention.
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_grant <= PORT_IF;
    end else if (take) begin
      last_grant <= grant;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Fetch / load-store arbiter that masters the memory unit's start/busy bus.
//   clk, reset            : clock, synchronous active-low reset
//   init_done             : memory unit ready; nothing issues while low
//   if_req/if_addr        : fetch request (level, held until if_ack)
//   if_ack/if_q           : one-cycle ack, fetch data held until next ack
//   d_req/d_we/d_addr/d_data : data request (level, held until d_ack)
//   d_ack/d_q             : one-cycle ack, load data held until next ack
//   err                   : pulses with the ack of a transfer that timed out
//   mem_address/mem_data/mem_we/mem_start : registered memory bus
//   mem_busy/mem_q        : memory unit status and read data
//
// state | meaning
// IDLE  | waiting for a request, init_done and memory not busy
// ISSUE | mem_start high, waiting for mem_busy to rise
// WAIT  | memory busy, waiting for mem_busy to fall
// DONE  | ack (and err on timeout) pulsed, mem_start low
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init_done,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_q,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_data,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_q,
  output logic              err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_we,
  output logic              mem_start,
  input  logic              mem_busy,
  input  logic [DATA_W-1:0] mem_q
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t           state;
  logic             grant_port;
  logic             sel_port;
  logic             issue;
  logic [CNT_W-1:0] wd_cnt;
  logic             wd_expired;
  logic             fin_ok;
  logic             fin_to;

  assign issue      = (state == IDLE) && init_done && !mem_busy && (if_req || d_req);
  // wd_cnt holds the number of ISSUE/WAIT cycles already completed.
  assign wd_expired = (wd_cnt == CNT_W'(TIMEOUT - 1));
  // A real completion wins over the watchdog when both happen in the same cycle.
  assign fin_ok     = (state == WAIT) && !mem_busy;
  assign fin_to     = ((state == ISSUE) || ((state == WAIT) && mem_busy)) && wd_expired;

  mem_rr_select u_rr_select (
    .clk    (clk),
    .reset  (reset),
    .if_req (if_req),
    .d_req  (d_req),
    .take   (issue),
    .grant  (sel_port)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      grant_port  <= PORT_IF;
      wd_cnt      <= '0;
      mem_address <= '0;
      mem_data    <= '0;
      mem_we      <= 1'b0;
      mem_start   <= 1'b0;
      if_q        <= '0;
      d_q         <= '0;
      if_ack      <= 1'b0;
      d_ack       <= 1'b0;
      err         <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      err    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (issue) begin
            grant_port <= sel_port;
            wd_cnt     <= '0;
            mem_start  <= 1'b1;
            if (sel_port == PORT_D) begin
              mem_address <= d_addr;
              mem_data    <= d_data;
              mem_we      <= d_we;
            end else begin
              // Fetches carry no write data; mem_data keeps its last value.
              mem_address <= if_addr;
              mem_we      <= 1'b0;
            end
            state <= ISSUE;
          end
        end
        ISSUE, WAIT: begin
          wd_cnt <= wd_cnt + 1'b1;
          if (fin_ok || fin_to) begin
            // Dropping start here keeps it low before the memory's next negedge.
            mem_start <= 1'b0;
            err       <= fin_to;
            state     <= DONE;
            if (grant_port == PORT_D) begin
              d_q   <= fin_ok ? mem_q : '0;
              d_ack <= 1'b1;
            end else begin
              if_q   <= fin_ok ? mem_q : '0;
              if_ack <= 1'b1;
            end
          end else if ((state == ISSUE) && mem_busy) begin
            state <= WAIT;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter with a behavioural memory unit.
module tb_mem_bus_arbiter;

  localparam int AW = 27;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          init_done;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_q;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_data;
  logic          d_ack;
  logic [DW-1:0] d_q;
  logic          err;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data;
  logic          mem_we;
  logic          mem_start;
  logic          mem_busy = 1'b0;
  logic [DW-1:0] mem_q = '0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .init_done(init_done),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_q(if_q),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_data(d_data),
    .d_ack(d_ack), .d_q(d_q), .err(err),
    .mem_address(mem_address), .mem_data(mem_data), .mem_we(mem_we),
    .mem_start(mem_start), .mem_busy(mem_busy), .mem_q(mem_q)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Unwritten locations read back a fixed scramble of the address.
  function automatic logic [31:0] rom_word(input logic [AW-1:0] a);
    return ({5'b0, a} * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // ---------------- memory unit model ----------------
  // Samples start on negedge, raises busy one negedge later, drops it L
  // negedges after that. Stores echo the inverted word on mem_q.
  logic [DW-1:0] mem_arr [logic [AW-1:0]];
  int            m_phase = 0;
  int            m_cnt = 0;
  int            lat_cfg = 1;
  bit            lat_random = 1'b0;
  bit            mem_dead = 1'b0;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic          m_we;

  always @(negedge clk) begin
    case (m_phase)
      0: if (mem_start === 1'b1 && !mem_dead) begin
        m_addr = mem_address; m_data = mem_data; m_we = mem_we; m_phase = 1;
      end
      1: begin
        mem_busy = 1'b1;
        m_cnt = lat_random ? int'($urandom_range(1, 6)) : lat_cfg;
        m_phase = 2;
      end
      default: begin
        m_cnt--;
        if (m_cnt == 0) begin
          mem_busy = 1'b0;
          m_phase = 0;
          if (m_we) begin
            mem_arr[m_addr] = m_data;
            mem_q = ~m_data;
          end else begin
            mem_q = mem_arr.exists(m_addr) ? mem_arr[m_addr] : rom_word(m_addr);
          end
        end
      end
    endcase
  end

  // ---------------- reference model and scoreboard ----------------
  typedef struct { logic [DW-1:0] q; logic e; } exp_t;
  exp_t          exp_if[$];
  exp_t          exp_d[$];
  int            ack_log[$];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];

  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : rom_word(a);
  endfunction

  // Expected response of one transfer, pushed when the request is raised.
  task automatic push_exp(input bit port, input bit we, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input bit to_exp);
    exp_t e;
    if (to_exp) e = '{'0, 1'b1};
    else if (port && we) e = '{~wd, 1'b0};
    else e = '{ref_read(a), 1'b0};
    if (port && we && !to_exp) ref_mem[a] = wd;
    if (port) exp_d.push_back(e); else exp_if.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (if_ack || d_ack) begin
        check("ack_onehot", if_ack & d_ack, 1'b0);
        check("start_low_at_ack", mem_start, 1'b0);
      end
      if (err && !if_ack && !d_ack) check("err_without_ack", err, 1'b0);
      if (if_ack) begin
        ack_log.push_back(0);
        if (exp_if.size() == 0) check("if_unexpected_ack", if_ack, 1'b0);
        else begin
          e = exp_if.pop_front();
          check("if_q", if_q, e.q);
          check("if_err", err, e.e);
        end
      end
      if (d_ack) begin
        ack_log.push_back(1);
        if (exp_d.size() == 0) check("d_unexpected_ack", d_ack, 1'b0);
        else begin
          e = exp_d.pop_front();
          check("d_q", d_q, e.q);
          check("d_err", err, e.e);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_req(input bit port, input logic v);
    if (port) d_req = v; else if_req = v;
  endtask

  task automatic wait_ack(input bit port, input string tag);
    bit got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk); #1;
      if (port ? d_ack : if_ack) got = 1'b1;
    end
    set_req(port, 1'b0);
    check({tag, "_ack_seen"}, got, 1'b1);
  endtask

  // Single transfer with latency and bus-hold checks; k counts cycles after the request cycle.
  task automatic xfer(input bit port, input bit we, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd, input int lat_exp, input bit to_exp,
                      input string tag);
    int k = 0;
    bit hold_ok = 1'b1;
    bit got = 1'b0;
    push_exp(port, we, a, wd, to_exp);
    @(posedge clk); #1;
    if (port) begin d_we = we; d_addr = a; d_data = wd; end else if_addr = a;
    set_req(port, 1'b1);
    while (!got && k < 60) begin
      @(posedge clk); #1;
      k++;
      if (k == 1) check({tag, "_start_n1"}, mem_start, 1'b1);
      if (mem_address !== a || mem_we !== (port & we) || (port && we && mem_data !== wd))
        hold_ok = 1'b0;
      if (port ? d_ack : if_ack) got = 1'b1;
    end
    set_req(port, 1'b0);
    check({tag, "_ack_cycle"}, k, lat_exp);
    check({tag, "_bus_hold"}, hold_ok, 1'b1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_mem_start"}, mem_start, 1'b0);
    check({tag, "_mem_we"}, mem_we, 1'b0);
    check({tag, "_mem_address"}, mem_address, '0);
    check({tag, "_mem_data"}, mem_data, '0);
    check({tag, "_if_q"}, if_q, '0);
    check({tag, "_d_q"}, d_q, '0);
    check({tag, "_ack_err"}, {if_ack, d_ack, err}, 3'b000);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  // ---------------- random traffic drivers ----------------
  task automatic drive_fetch(input int n);
    logic [AW-1:0] a;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      a = 27'h400000 | AW'($urandom_range(0, 255));
      push_exp(1'b0, 1'b0, a, '0, 1'b0);
      if_addr = a;
      if_req = 1'b1;
      wait_ack(1'b0, "rnd_if");
    end
  endtask

  task automatic drive_data(input int n);
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    bit we;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      a = 27'h10 + AW'($urandom_range(0, 7));
      wd = $urandom;
      we = 1'($urandom_range(0, 1));
      push_exp(1'b1, we, a, wd, 1'b0);
      d_addr = a; d_data = wd; d_we = we;
      d_req = 1'b1;
      wait_ack(1'b1, "rnd_d");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit");
    $fatal(1, "time limit");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n_ack;
    int busy_cycles;
    bit seen;
    logic [3:0] ord;

    reset = 1'b0; init_done = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_data = '0;
    mem_arr[27'hC02430] = 32'hDEAD_BEEF;
    ref_mem[27'hC02430] = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    reset = 1'b1;

    // single fetch, L=1
    lat_cfg = 1;
    xfer(1'b0, 1'b0, 27'hC02430, '0, 4, 1'b0, "fetch");

    // store then load, L=5
    lat_cfg = 5;
    xfer(1'b1, 1'b1, 27'h10, 32'h1234_5678, 8, 1'b0, "store");
    xfer(1'b1, 1'b0, 27'h10, '0, 8, 1'b0, "load");

    // contention after reset
    lat_cfg = 1;
    pulse_reset();
    ack_log.delete();
    if_addr = 27'h400100; d_addr = 27'h10; d_we = 1'b0;
    for (int i = 0; i < 2; i++) begin
      push_exp(1'b1, 1'b0, 27'h10, '0, 1'b0);
      push_exp(1'b0, 1'b0, 27'h400100, '0, 1'b0);
    end
    if_req = 1'b1; d_req = 1'b1;
    n_ack = 0;
    for (int i = 0; i < 100 && n_ack < 4; i++) begin
      @(posedge clk); #1;
      if (if_ack || d_ack) n_ack++;
    end
    if_req = 1'b0; d_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    ord = '0;
    for (int i = 0; i < 4; i++) if (i < ack_log.size()) ord[3-i] = ack_log[i][0];
    check("rr_order_len", ack_log.size(), 4);
    check("rr_order", ord, 4'b1010);

    // init gating
    init_done = 1'b0;
    push_exp(1'b1, 1'b0, 27'h11, '0, 1'b0);
    d_addr = 27'h11; d_we = 1'b0; d_req = 1'b1;
    seen = 1'b0;
    repeat (50) begin
      @(posedge clk); #1;
      if (mem_start) seen = 1'b1;
    end
    check("init_gate_no_start", seen, 1'b0);
    init_done = 1'b1;
    @(posedge clk); #1;
    check("init_gate_start_next", mem_start, 1'b1);
    wait_ack(1'b1, "init_gate");

    // watchdog timeout, memory never responds
    mem_dead = 1'b1;
    xfer(1'b1, 1'b0, 27'h12, '0, TO + 1, 1'b1, "timeout");
    mem_dead = 1'b0;
    xfer(1'b0, 1'b0, 27'h400010, '0, 4, 1'b0, "after_timeout");

    // reset during WAIT with memory still busy
    lat_cfg = 12;
    @(posedge clk); #1;
    d_addr = 27'h13; d_we = 1'b0; d_req = 1'b1;
    for (int i = 0; i < 20 && !mem_busy; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0; d_req = 1'b0;
    @(posedge clk); #1;
    check_reset_vals("mid_reset");
    reset = 1'b1;
    lat_cfg = 1;
    push_exp(1'b0, 1'b0, 27'h400200, '0, 1'b0);
    if_addr = 27'h400200; if_req = 1'b1;
    seen = 1'b0; busy_cycles = 0; n_ack = 0;
    for (int i = 0; i < 40 && mem_busy; i++) begin
      @(posedge clk); #1;
      if (mem_busy) begin
        busy_cycles++;
        if (mem_start) seen = 1'b1;
      end
      if (if_ack || d_ack) n_ack++;
    end
    check("mid_reset_busy_seen", busy_cycles > 0, 1'b1);
    check("mid_reset_no_start_while_busy", seen, 1'b0);
    check("mid_reset_no_ack", n_ack, 0);
    wait_ack(1'b0, "mid_reset_fetch");

    // randomized concurrent traffic
    lat_random = 1'b1;
    fork
      drive_fetch(25);
      drive_data(25);
    join
    repeat (5) @(posedge clk);
    #1;
    check("if_queue_drained", exp_if.size(), 0);
    check("d_queue_drained", exp_d.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
